mvm_uart_system: RTL and testbench

UART-attached signed matrix-vector multiplier. It receives one frame of K matrix and x vector bytes over a UART line, computes y = K·x, and returns y as a byte stream on a UART TX line. It is a self-contained top level with one clock and two serial pins; the host side is a PC or a testbench UART model.

---
 rtl/mvm_uart_pkg.sv | 43 ++++
 rtl/mvm_uart_system_uart_rx.sv | 84 ++++++++
 rtl/mvm_uart_system.sv | 179 +++++++++++++++++
 tb/tb_mvm_uart_system.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mvm_uart_pkg.sv
// Shared widths, state encodings and bus layouts for the UART-attached
// signed matrix-vector multiplier.
package mvm_uart_pkg;

    localparam int CLOCKS_PER_PULSE = 4;
    localparam int BITS_PER_WORD    = 8;
    localparam int PACKET_SIZE_TX   = BITS_PER_WORD + 5;
    localparam int R                = 8;
    localparam int C                = 8;
    localparam int W_X              = 8;
    localparam int W_K              = 8;

    localparam int W_Y        = W_X + W_K + $clog2(C);
    localparam int W_P        = W_X + W_K;
    localparam int W_BUS_KX   = R * C * W_K + C * W_X;
    localparam int W_BUS_Y    = R * W_Y;
    localparam int N_WORDS_KX = W_BUS_KX / BITS_PER_WORD;
    localparam int N_WORDS_Y  = W_BUS_Y / BITS_PER_WORD;

    localparam int W_CYC   = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int W_RXBIT = $clog2(BITS_PER_WORD);
    localparam int W_TXBIT = $clog2(PACKET_SIZE_TX);
    localparam int W_KXCNT = $clog2(N_WORDS_KX);
    localparam int W_YCNT  = $clog2(N_WORDS_Y);
    localparam int W_COL   = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {TX_IDLE, TX_SEND} tx_state_t;

    // x occupies the low bits, K sits above it in row-major order
    typedef struct packed {
        logic [R-1:0][C-1:0][W_K-1:0] k;
        logic [C-1:0][W_X-1:0]        x;
    } kx_bus_t;

    typedef logic [R-1:0][W_Y-1:0] y_bus_t;

    // start bit, data LSB-first, then idle-level padding
    function automatic logic [PACKET_SIZE_TX-1:0] tx_frame(input logic [BITS_PER_WORD-1:0] b);
        return {{(PACKET_SIZE_TX-BITS_PER_WORD-1){1'b1}}, b, 1'b0};
    endfunction

endpackage

// File: rtl/mvm_uart_system_uart_rx.sv
// UART receiver: 2-flop synchronizer plus start/data/stop FSM.
// Emits one valid pulse per byte whose stop bit sampled high.
module uart_rx
    import mvm_uart_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    output logic [BITS_PER_WORD-1:0] data,
    output logic                     valid
);

    localparam logic [W_CYC-1:0]   HALF_LAST = W_CYC'(CLOCKS_PER_PULSE/2 - 1);
    localparam logic [W_CYC-1:0]   BIT_LAST  = W_CYC'(CLOCKS_PER_PULSE - 1);
    localparam logic [W_RXBIT-1:0] DATA_LAST = W_RXBIT'(BITS_PER_WORD - 1);

    logic                     rx_meta, rx_sync;
    rx_state_t                state_q, state_d;
    logic [W_CYC-1:0]         cnt_q, cnt_d;
    logic [W_RXBIT-1:0]       bit_q, bit_d;
    logic [BITS_PER_WORD-1:0] shift_q, shift_d;
    logic                     valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid   <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid   <= valid_d;
        end
    end

    assign data = shift_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + W_CYC'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_sync) state_d = RX_START;
            end
            RX_START: begin
                // mid-start-bit recheck rejects short glitches
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync, shift_q[BITS_PER_WORD-1:1]};
                    bit_d   = bit_q + W_RXBIT'(1);
                    if (bit_q == DATA_LAST) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    valid_d = rx_sync;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/mvm_uart_system.sv
// UART-attached signed matrix-vector multiplier: assembles a {K, x} frame
// from RX bytes, computes y = K*x with R parallel MACs, streams y out on TX.
module mvm_uart_system
    import mvm_uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic tx
);

    if ((W_BUS_KX % BITS_PER_WORD) != 0 || (W_BUS_Y % BITS_PER_WORD) != 0) begin : g_bus_check
        $error("KX and Y bus widths must be multiples of BITS_PER_WORD");
    end
    if (PACKET_SIZE_TX < BITS_PER_WORD + 2) begin : g_packet_check
        $error("PACKET_SIZE_TX must be at least BITS_PER_WORD+2");
    end

    localparam logic [W_KXCNT-1:0] KX_LAST    = W_KXCNT'(N_WORDS_KX - 1);
    localparam logic [W_YCNT-1:0]  Y_LAST     = W_YCNT'(N_WORDS_Y - 1);
    localparam logic [W_COL-1:0]   COL_LAST   = W_COL'(C - 1);
    localparam logic [W_TXBIT-1:0] TXBIT_LAST = W_TXBIT'(PACKET_SIZE_TX - 1);
    localparam logic [W_CYC-1:0]   CYC_LAST   = W_CYC'(CLOCKS_PER_PULSE - 1);

    logic [BITS_PER_WORD-1:0] rx_data;
    logic                     rx_valid;

    uart_rx u_rx (
        .clk   (clk),
        .rst   (rst),
        .rx    (rx),
        .data  (rx_data),
        .valid (rx_valid)
    );

    logic [N_WORDS_KX-1:0][BITS_PER_WORD-1:0] kx_words;
    logic [W_KXCNT-1:0]                       byte_cnt;
    logic                                     frame_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (rx_valid) begin
                kx_words[byte_cnt] <= rx_data;
                if (byte_cnt == KX_LAST) begin
                    byte_cnt   <= '0;
                    frame_done <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + W_KXCNT'(1);
                end
            end
        end
    end

    // comp_busy covers both the MAC pass and holding its result until TX frees
    kx_bus_t           kx_comp;
    logic              comp_busy, running;
    logic [W_COL-1:0]  col;
    logic              mac_clear, tx_load;
    y_bus_t            acc_y, y_reg;
    tx_state_t         tx_state_q, tx_state_d;

    assign mac_clear = frame_done && !comp_busy;
    assign tx_load   = comp_busy && !running && (tx_state_q == TX_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            comp_busy <= 1'b0;
            running   <= 1'b0;
            col       <= '0;
        end else if (mac_clear) begin
            kx_comp   <= kx_words;
            comp_busy <= 1'b1;
            running   <= 1'b1;
            col       <= '0;
        end else if (running) begin
            col <= col + W_COL'(1);
            if (col == COL_LAST) running <= 1'b0;
        end else if (tx_load) begin
            comp_busy <= 1'b0;
        end
    end

    for (genvar r = 0; r < R; r++) begin : g_lane
        logic [W_K-1:0] k_el;
        logic [W_X-1:0] x_el;
        logic [W_P-1:0] k_ext, x_ext, prod;
        logic [W_Y-1:0] acc;

        assign k_el  = kx_comp.k[r][col];
        assign x_el  = kx_comp.x[col];
        // low W_P bits of the sign-extended product are the exact signed product
        assign k_ext = {{W_X{k_el[W_K-1]}}, k_el};
        assign x_ext = {{W_K{x_el[W_X-1]}}, x_el};
        assign prod  = k_ext * x_ext;

        always_ff @(posedge clk) begin
            if (mac_clear)    acc <= '0;
            else if (running) acc <= acc + {{(W_Y-W_P){prod[W_P-1]}}, prod};
        end

        assign acc_y[r] = acc;
    end

    always_ff @(posedge clk) begin
        if (tx_load) y_reg <= acc_y;
    end

    logic [N_WORDS_Y-1:0][BITS_PER_WORD-1:0] y_words;
    logic [W_YCNT-1:0]                       word_q, word_d;
    logic [W_TXBIT-1:0]                      txbit_q, txbit_d;
    logic [W_CYC-1:0]                        cyc_q, cyc_d;
    logic [PACKET_SIZE_TX-1:0]               sr_q, sr_d;

    assign y_words = y_reg;
    assign tx      = sr_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            word_q     <= '0;
            txbit_q    <= '0;
            cyc_q      <= '0;
            sr_q       <= '1;
        end else begin
            tx_state_q <= tx_state_d;
            word_q     <= word_d;
            txbit_q    <= txbit_d;
            cyc_q      <= cyc_d;
            sr_q       <= sr_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        word_d     = word_q;
        txbit_d    = txbit_q;
        cyc_d      = cyc_q;
        sr_d       = sr_q;
        unique case (tx_state_q)
            TX_IDLE: begin
                sr_d = '1;
                if (tx_load) begin
                    // y_reg loads this same edge, so word 0 comes from the MACs
                    tx_state_d = TX_SEND;
                    word_d     = '0;
                    txbit_d    = '0;
                    cyc_d      = '0;
                    sr_d       = tx_frame(acc_y[0][BITS_PER_WORD-1:0]);
                end
            end
            TX_SEND: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (txbit_q == TXBIT_LAST) begin
                        txbit_d = '0;
                        if (word_q == Y_LAST) begin
                            tx_state_d = TX_IDLE;
                            sr_d       = '1;
                        end else begin
                            word_d = word_q + W_YCNT'(1);
                            sr_d   = tx_frame(y_words[word_q + W_YCNT'(1)]);
                        end
                    end else begin
                        txbit_d = txbit_q + W_TXBIT'(1);
                        sr_d    = {1'b1, sr_q[PACKET_SIZE_TX-1:1]};
                    end
                end else begin
                    cyc_d = cyc_q + W_CYC'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mvm_uart_system.sv
// Randomized scoreboard bench: frames are driven on rx, a reference MVM
// queues the expected y bytes, and a UART monitor on tx pops and compares.
module tb_mvm_uart_system;

    localparam int CPP   = 4;
    localparam int R     = 8;
    localparam int C     = 8;
    localparam int W_Y   = 19;
    localparam int N_KX  = 72;
    localparam int N_Y   = 19;
    localparam int N_PAD = 4;

    typedef logic [7:0] frame_t [N_KX];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic tx;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    mvm_uart_system dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .tx  (tx)
    );

    always #5 clk = ~clk;

    // reference: x[c] is byte c, K[r][c] is byte C + r*C + c, y packed at r*W_Y
    task automatic push_expected(input frame_t f);
        int y;
        logic [N_Y*8-1:0] ybus;
        ybus = '0;
        for (int r = 0; r < R; r++) begin
            y = 0;
            for (int c = 0; c < C; c++)
                y += int'($signed(f[C + r*C + c])) * int'($signed(f[c]));
            ybus[r*W_Y +: W_Y] = y[W_Y-1:0];
        end
        for (int m = 0; m < N_Y; m++) exp_q.push_back(ybus[m*8 +: 8]);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap);
        rx = 1'b0;
        repeat (CPP) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPP) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPP) @(negedge clk);
        rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input frame_t f, input int max_gap);
        for (int i = 0; i < N_KX; i++) send_byte(f[i], 1'b1, $urandom_range(1, max_gap));
    endtask

    task automatic fill(output frame_t f, input logic [7:0] kval, input logic [7:0] xval);
        for (int i = 0; i < N_KX; i++) f[i] = (i < C) ? xval : kval;
    endtask

    task automatic fill_random(output frame_t f);
        for (int i = 0; i < N_KX; i++) f[i] = 8'($urandom);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d result bytes outstanding, required 0", exp_q.size());
        end
        repeat (4 * CPP) @(negedge clk);
    endtask

    initial begin : monitor
        logic [7:0] b;
        logic [7:0] exp_b;
        int nbyte;
        nbyte = 0;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                repeat (CPP/2) @(negedge clk);
                checks++;
                if (tx !== 1'b0) begin
                    errors++;
                    $display("FAIL tx_start: byte %0d start bit got %b, required 0", nbyte, tx);
                end
                for (int i = 0; i < 8; i++) begin
                    repeat (CPP) @(negedge clk);
                    b[i] = tx;
                end
                for (int p = 0; p < N_PAD; p++) begin
                    repeat (CPP) @(negedge clk);
                    checks++;
                    if (tx !== 1'b1) begin
                        errors++;
                        $display("FAIL tx_pad: byte %0d pad bit %0d got %b, required 1", nbyte, p, tx);
                    end
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_extra: byte %0d got %02h, required no byte", nbyte, b);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (b !== exp_b) begin
                        errors++;
                        $display("FAIL tx_byte: byte %0d got %02h, required %02h", nbyte, b, exp_b);
                    end
                end
                nbyte++;
            end
        end
    end

    initial begin : watchdog
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        frame_t f;
        frame_t g;

        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx: got %b, required 1", tx);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // directed frames
        fill(f, 8'h00, 8'h00); push_expected(f); send_frame(f, 2);
        fill(f, 8'h01, 8'h01); push_expected(f); send_frame(f, 2);
        fill(f, 8'h80, 8'h80); push_expected(f); send_frame(f, 2);
        fill(f, 8'h80, 8'h7F); push_expected(f); send_frame(f, 2);

        // random frames with random byte and frame gaps
        for (int n = 0; n < 10; n++) begin
            fill_random(f);
            push_expected(f);
            send_frame(f, 20);
            repeat ($urandom_range(1, 100)) @(negedge clk);
        end

        // framing error on byte 5: that byte must not enter the frame
        fill_random(f);
        push_expected(f);
        for (int i = 0; i < 5; i++) send_byte(f[i], 1'b1, $urandom_range(1, 20));
        send_byte(8'($urandom), 1'b0, 3 * CPP);
        for (int i = 5; i < N_KX; i++) send_byte(f[i], 1'b1, $urandom_range(1, 20));

        drain(5000);

        // partial frame discarded by a one-cycle reset
        fill_random(g);
        for (int i = 0; i < 30; i++) send_byte(g[i], 1'b1, $urandom_range(1, 20));
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_tx: got %b, required 1", tx);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        fill_random(f);
        push_expected(f);
        send_frame(f, 20);

        drain(5000);
        repeat (200) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
